// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcodes, memory FSM
// state encoding and pipeline fill depth.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [2:0] FILL_DEPTH = 3'd4;

  // Encodings are fixed: IDLE is deliberately 3, not 0.
  typedef enum logic [1:0] {
    MEM_IND   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_IDLE  = 2'd3
  } mem_state_e;

  function automatic logic is_alu_result(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access state machine, driven by the opcode held in execute.
// Indirect accesses (LDI/STI) take an extra IND phase before READ/WRITE.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode_exec,
  input  logic       complete_data,
  output mem_state_e mem_state
);

  mem_state_e state_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if ((opcode_exec == OP_LD) || (opcode_exec == OP_LDR))
            state_q <= MEM_READ;
          else if ((opcode_exec == OP_ST) || (opcode_exec == OP_STR))
            state_q <= MEM_WRITE;
          else if ((opcode_exec == OP_LDI) || (opcode_exec == OP_STI))
            state_q <= MEM_IND;
        end
        MEM_IND: begin
          if (complete_data)
            state_q <= (opcode_exec == OP_STI) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ, MEM_WRITE: begin
          if (complete_data) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign mem_state = state_q;

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline controller: stage enables, branch resolution and ALU bypass.
// Optional feature macro: LC3_CTRL_BYPASS_EN enables bypass_alu_1/2 generation.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] imem_dout,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  mem_state_e mem_state_w;
  logic [2:0] fill_q, fill_d;
  logic [1:0] br_cnt_q, br_cnt_d;
  logic       mem_idle;
  logic       br_load;
  logic [3:0] op_fetch, op_dec, op_exec;

  assign op_fetch = imem_dout[15:12];
  assign op_dec   = ir[15:12];
  assign op_exec  = ir_exec[15:12];

  lc3_mem_fsm u_mem_fsm (
    .clock         (clock),
    .reset         (reset),
    .opcode_exec   (op_exec),
    .complete_data (complete_data),
    .mem_state     (mem_state_w)
  );

  assign mem_state = mem_state_w;
  assign mem_idle  = (mem_state_w == MEM_IDLE);

  // Enables are gated by reset so nothing leaks out while reset is held,
  // even when reset lands in the middle of a memory access.
  always_comb begin
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    if (reset) begin
      if (mem_idle) begin
        enable_fetch     = (fill_q >= 3'd1) && complete_instr && (br_cnt_q == 2'd0);
        enable_updatePC  = enable_fetch;
        enable_decode    = (fill_q >= 3'd2) && complete_instr;
        enable_execute   = (fill_q >= 3'd3);
        enable_writeback = (fill_q >= FILL_DEPTH);
      end else if ((mem_state_w == MEM_READ) && complete_data) begin
        enable_writeback = 1'b1;
      end
    end
  end

  assign fill_d  = (fill_q == FILL_DEPTH) ? fill_q : fill_q + 3'd1;
  assign br_load = enable_fetch && ((op_fetch == OP_BR) || (op_fetch == OP_JMP));

  // Counter holds fetch off until the branch reaches execute; frozen in a stall.
  always_comb begin
    br_cnt_d = br_cnt_q;
    if (br_load)
      br_cnt_d = 2'd3;
    else if ((br_cnt_q != 2'd0) && mem_idle)
      br_cnt_d = br_cnt_q - 2'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fill_q   <= 3'd0;
      br_cnt_q <= 2'd0;
    end else begin
      fill_q   <= fill_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  assign br_taken = reset && (br_cnt_q == 2'd1) &&
                    ((op_exec == OP_JMP) ||
                     ((op_exec == OP_BR) && ((ir_exec[11:9] & psr) != 3'b000)));

`ifdef LC3_CTRL_BYPASS_EN
  logic exec_alu;
  logic dec_uses_sr1;
  logic dec_uses_sr2;

  assign exec_alu     = is_alu_result(op_exec);
  assign dec_uses_sr1 = (op_dec == OP_ADD) || (op_dec == OP_AND) || (op_dec == OP_NOT) ||
                        (op_dec == OP_LDR) || (op_dec == OP_STR) || (op_dec == OP_JMP);
  assign dec_uses_sr2 = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !ir[5];

  assign bypass_alu_1 = reset && exec_alu && dec_uses_sr1 && (ir_exec[11:9] == ir[8:6]);
  assign bypass_alu_2 = reset && exec_alu && dec_uses_sr2 && (ir_exec[11:9] == ir[2:0]);
`else
  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{imem_dout[11:0], ir_exec[8:0], ir};

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller; expected output vectors are queued
// as each step is driven and popped when the cycle's outputs are sampled.
module tb_lc3_pipe_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] imem_dout;
  logic [15:0] ir;
  logic [15:0] ir_exec;
  logic [2:0]  psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        br_taken, bypass_alu_1, bypass_alu_2;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

`ifdef LC3_CTRL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  localparam logic [15:0] I_ADD_R1  = 16'h1283; // ADD R1,R2,R3
  localparam logic [15:0] I_ADD_IND = 16'h14C4; // ADD R2,R3,R4 (no dependency on R1)
  localparam logic [15:0] I_AND_RR  = 16'h5841; // AND R4,R1,R1
  localparam logic [15:0] I_AND_IMM = 16'h5861; // AND R4,R1,#1
  localparam logic [15:0] I_LDR     = 16'h6840; // LDR R4,R1,#0
  localparam logic [15:0] I_LDI     = 16'hA200;
  localparam logic [15:0] I_STR     = 16'h7240;
  localparam logic [15:0] I_LD      = 16'h2200;
  localparam logic [15:0] I_BR_Z    = 16'h0405; // BRz
  localparam logic [15:0] I_JMP     = 16'hC1C0; // JMP R7

  lc3_pipe_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .imem_dout        (imem_dout),
    .ir               (ir),
    .ir_exec          (ir_exec),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .mem_state        (mem_state),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Vector layout: {updPC, fetch, decode, execute, writeback, mem_state[1:0], br_taken, byp1, byp2}
  task automatic step(input string tag, input logic [4:0] en, input logic [1:0] ms,
                      input logic br, input logic b1, input logic b2);
    logic [9:0] obs;
    logic [9:0] exp_v;
    exp_q.push_back({en, ms, br, b1, b2});
    @(negedge clock);
    obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
           mem_state, br_taken, bypass_alu_1, bypass_alu_2};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    imem_dout      = I_ADD_IND;
    ir             = I_ADD_IND;
    ir_exec        = I_ADD_R1;
    psr            = 3'b010;

    // Reset held three cycles, then pipeline fill.
    step("reset_c0", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("reset_c1", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("reset_c2", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("fill_0", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("fill_1", 5'b11000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("fill_2", 5'b11100, 2'd3, 1'b0, 1'b0, 1'b0);
    step("fill_3", 5'b11110, 2'd3, 1'b0, 1'b0, 1'b0);
    step("fill_4", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("fill_sat", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // complete_data while idle has no effect.
    complete_data = 1'b1;
    step("idle_cdata", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b0;

    // LDI: IND for 2 cycles, READ for 3, writeback only in the last READ cycle.
    ir_exec = I_LDI;
    step("ldi_issue", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("ldi_ind0", 5'b00000, 2'd0, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b1;
    step("ldi_ind1", 5'b00000, 2'd0, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b0;
    step("ldi_rd0", 5'b00000, 2'd1, 1'b0, 1'b0, 1'b0);
    step("ldi_rd1", 5'b00000, 2'd1, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b1;
    ir_exec = I_ADD_R1;
    step("ldi_rd2_wb", 5'b00001, 2'd1, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b0;
    step("ldi_done", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // STR: one WRITE stall cycle, no writeback pulse.
    ir_exec = I_STR;
    step("str_issue", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b1;
    ir_exec = I_ADD_R1;
    step("str_write", 5'b00000, 2'd2, 1'b0, 1'b0, 1'b0);
    complete_data = 1'b0;
    step("str_done", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // complete_instr low: front stages held, no branch load from a stalled fetch.
    imem_dout = I_BR_Z;
    complete_instr = 1'b0;
    step("cinstr_low", 5'b00011, 2'd3, 1'b0, 1'b0, 1'b0);
    imem_dout = I_ADD_IND;
    complete_instr = 1'b1;
    step("cinstr_back", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // BRz with Z set: taken in the third blocked cycle.
    imem_dout = I_BR_Z;
    step("brz_fetch", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    imem_dout = I_ADD_IND;
    ir_exec = I_BR_Z;
    step("brz_c3", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("brz_c2", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("brz_c1_taken", 5'b00111, 2'd3, 1'b1, 1'b0, 1'b0);
    ir_exec = I_ADD_R1;
    step("brz_after", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // BRz with N set: not taken.
    psr = 3'b100;
    imem_dout = I_BR_Z;
    step("brn_fetch", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    imem_dout = I_ADD_IND;
    ir_exec = I_BR_Z;
    step("brn_c3", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("brn_c2", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("brn_c1_not", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    ir_exec = I_ADD_R1;
    step("brn_after", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // JMP is always taken.
    imem_dout = I_JMP;
    step("jmp_fetch", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    imem_dout = I_ADD_IND;
    ir_exec = I_JMP;
    step("jmp_c3", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("jmp_c2", 5'b00111, 2'd3, 1'b0, 1'b0, 1'b0);
    step("jmp_c1_taken", 5'b00111, 2'd3, 1'b1, 1'b0, 1'b0);
    ir_exec = I_ADD_R1;
    psr = 3'b010;
    step("jmp_after", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);

    // Bypass selects.
    ir = I_AND_RR;
    step("byp_and_rr", 5'b11111, 2'd3, 1'b0, BYP, BYP);
    ir = I_AND_IMM;
    step("byp_and_imm", 5'b11111, 2'd3, 1'b0, BYP, 1'b0);
    ir = I_LDR;
    step("byp_ldr", 5'b11111, 2'd3, 1'b0, BYP, 1'b0);
    ir_exec = I_LD;
    ir = I_AND_RR;
    step("byp_non_alu", 5'b11111, 2'd3, 1'b0, 1'b0, 1'b0);
    ir = I_ADD_IND;

    // Reset asserted mid-READ discards the access.
    ir_exec = I_ADD_R1;
    step("ld_read0", 5'b00000, 2'd1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("ld_read_rst", 5'b00000, 2'd1, 1'b0, 1'b0, 1'b0);
    step("rst_idle", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("refill_0", 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("refill_1", 5'b11000, 2'd3, 1'b0, 1'b0, 1'b0);
    step("refill_2", 5'b11100, 2'd3, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_controller.md
# lc3_pipe_controller

Pipeline controller for the LC-3 datapath. It sequences the fetch, decode, execute and writeback stages, and runs the data-memory access state machine. It also resolves control hazards from BR/JMP and generates ALU bypass selects. It sits beside the decode stage: it consumes the instruction words the datapath moves between stages and drives the stage enables the decode and execute stages sample.

## Interface
No parameters; widths are fixed by the LC-3 ISA.
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clock
- complete_instr  in  1  instruction memory returned data this cycle
- complete_data  in  1  data memory access finished this cycle
- imem_dout  in  16  instruction currently being fetched
- ir  in  16  instruction held in decode (decode instr_dout)
- ir_exec  in  16  instruction held in execute
- psr  in  3  N,Z,P condition flags
- enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables
- mem_state  out  2  memory FSM state
- br_taken  out  1  load PC with branch/jump target
- bypass_alu_1, bypass_alu_2  out  1 each  forward execute ALU result to operand 1/2

## Operation
- Opcodes (ir[15:12]): BR 0000, ADD 0001, LD 0010, ST 0011, AND 0101, LDR 0110, STR 0111, NOT 1001, LDI 1010, STI 1011, JMP 1100, LEA 1110.
- Pipeline fill counter (0..4) after reset release:
  - updatePC/fetch enabled from cycle 1, decode from cycle 2, execute from 3, writeback from 4.
  - Saturates at 4.
- Memory FSM, with mem_state encoding IDLE=3, IND=0, READ=1, WRITE=2:
  - IDLE: ir_exec LD/LDR -> READ; ST/STR -> WRITE; LDI/STI -> IND; else stay.
  - IND: on complete_data -> READ (LDI) or WRITE (STI); else hold.
  - READ/WRITE: on complete_data -> IDLE; else hold.
- While mem_state != IDLE, all five enables are 0, except enable_writeback=1 in the READ cycle where complete_data=1.
- complete_instr=0 forces enable_updatePC, enable_fetch and enable_decode to 0. Execute and writeback are unaffected.
- Branch counter (2 bits):
  - Loads 3 when enable_fetch=1 and imem_dout is BR or JMP.
  - While nonzero, enable_updatePC=enable_fetch=0.
  - Decrements each cycle mem_state=IDLE.
- br_taken=1 when the branch counter equals 1 and ir_exec is JMP, or ir_exec is BR with (ir_exec[11:9] & psr) != 0.
- bypass_alu_1=1 when ir_exec is ADD/AND/NOT/LEA, ir is ADD/AND/NOT/LDR/STR/JMP, and ir_exec[11:9]==ir[8:6].
- bypass_alu_2=1 under the same ir_exec condition when ir is ADD/AND with ir[5]=0 and ir_exec[11:9]==ir[2:0].

## Timing
- Reset values: all enables 0, mem_state 3, br_taken 0, fill counter 0, branch counter 0, bypass 0.
- mem_state and the counters are registered. Enables, br_taken and bypass are combinational from registered state plus current inputs, with no added latency.
- Reset asserted mid-access returns mem_state to 3 on that edge, discarding the pending access.
- complete_data while IDLE is ignored.
- A branch fetch during a memory stall cannot occur, because enable_fetch=0 then.
- The branch counter freezes during a memory stall and resumes afterwards.

## Configuration
- LC3_CTRL_BYPASS_EN defined: bypass_alu_1/2 are generated as above.
- Not defined: bypass_alu_1/2 are tied 0 and no comparator logic exists. Software must separate dependent instructions.

## Structure
- Shared package lc3_ctrl_pkg holds:
  - opcode localparams;
  - mem_state typedef enum (IDLE, IND, READ, WRITE) with the fixed encodings above;
  - the fill depth constant (4).
- One sub-module, lc3_mem_fsm, owns the memory state machine. Inputs: ir_exec opcode, complete_data, reset. Output: mem_state.

## Test plan
- Reset held 3 cycles then released, ADD stream: all enables 0 and mem_state=3 during reset. Fetch enabled in cycle 1, writeback in cycle 4, all enables stay 1.
- LDI in execute, complete_data after 2 cycles, then after 3 more: mem_state 3->0->1->3. Enables 0 throughout; enable_writeback=1 only in the final READ cycle.
- STR with complete_data the next cycle: mem_state 3->2->3, one stall cycle, no writeback pulse.
- BR nzp=010 fetched with psr=010: fetch/updatePC 0 for 3 cycles, br_taken=1 in the third cycle. Repeat with psr=100: br_taken stays 0.
- ADD R1,R2,R3 in execute and AND R4,R1,R1 in decode with macro defined: bypass_alu_1=bypass_alu_2=1. Macro undefined: both 0.
- reset asserted while mem_state=1: next edge mem_state=3 and all enables 0.
